// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ byte
// sources, with packet lock and bounded waits on the transmitter and on the lock owner.
//
// state        | meaning
// S_IDLE       | no owner; round-robin pick among valid requesters
// S_ISSUE      | consume the owner's byte; tx_start/req_ready show up next cycle
// S_WAIT_BUSY  | wait for tx_busy to rise, bounded by BUSY_TIMEOUT
// S_WAIT_DONE  | frame on the wire; decide release or next byte when busy falls
// S_LOCK       | owner keeps the grant between packet bytes, bounded by LOCK_TIMEOUT
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 timeout
);

  localparam int MAX_TO = (LOCK_TIMEOUT > BUSY_TIMEOUT) ? LOCK_TIMEOUT : BUSY_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_TO) + 1;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_LOCK
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               timeout_q, timeout_d;

  logic               any_req;
  logic [IDX_W-1:0]   pick_idx;
  logic               release_owner;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Walk from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    any_req  = 1'b0;
    pick_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req_valid[rr_index(last_grant_q, off)]) begin
        any_req  = 1'b1;
        pick_idx = rr_index(last_grant_q, off);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    timeout_d     = timeout_q;
    release_owner = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gidx_d           = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tx_start_d  = 1'b1;
        tx_data_d   = req_data[8*int'(gidx_q) +: 8];
        req_ready_d = grant_q;
        last_d      = req_last[gidx_q];
        cnt_d       = BUSY_LOAD;
        state_d     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == '0) begin
          // Transmitter never answered: the byte is dropped, not retried.
          timeout_d     = 1'b1;
          release_owner = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            release_owner = 1'b1;
          end else if (req_valid[gidx_q]) begin
            state_d = S_ISSUE;
          end else begin
            cnt_d   = LOCK_LOAD;
            state_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        if (req_valid[gidx_q]) begin
          state_d = S_ISSUE;
        end else if (cnt_q == '0) begin
          release_owner = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    if (release_owner) begin
      grant_d      = '0;
      last_grant_d = gidx_q;
      state_d      = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gidx_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      timeout_q    <= timeout_d;
    end
  end

  assign req_ready = req_ready_q;
  assign grant     = grant_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and transmitter models run on the falling
// edge; directed scenarios plus randomized packets checked against a packet-level model.
module tb_uart_tx_arbiter;

  localparam int NR      = 2;
  localparam int LOCK_TO = 16;
  localparam int BUSY_TO = 8;
  localparam int CYC_MAX = 20000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            timeout;

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LOCK_TO), .BUSY_TIMEOUT(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // feed is appended only by the test process; the engine owns the read pointers and logs.
  logic [8:0] feed [NR][$];
  int         rd [NR];
  int         rise_cyc [NR];
  int         rdy_cnt [NR];
  int         cyc;
  logic [1:0] gh [CYC_MAX];
  logic       th [CYC_MAX];
  int         ev_cyc [$];
  logic [1:0] ev_g [$];
  logic [7:0] ev_d [$];
  logic [1:0] ev_r [$];
  bit         start_pend;
  int         busy_cnt;

  bit         tx_dead;
  int         ev_base;
  int         rdy_base [NR];
  int         checks;
  int         failures;

  initial begin : engine
    logic [8:0] h;
    bit         new_start;
    cyc = 0; start_pend = 1'b0; busy_cnt = 0; tx_busy = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NR; i++) begin rd[i] = 0; rise_cyc[i] = 0; rdy_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      new_start = 1'b0;
      if (cyc < CYC_MAX) begin gh[cyc] = grant; th[cyc] = timeout; end
      if (rst) begin
        for (int i = 0; i < NR; i++) rd[i] = feed[i].size();
        start_pend = 1'b0;
      end else begin
        if (tx_start) begin
          ev_cyc.push_back(cyc); ev_g.push_back(grant); ev_d.push_back(tx_data); ev_r.push_back(req_ready);
          new_start = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
          if (req_ready[i]) begin
            rdy_cnt[i]++;
            if (rd[i] < feed[i].size()) rd[i]++;
          end
        end
      end
      // Transmitter: busy rises one cycle after start and stays high for 10 cycles.
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (start_pend && !tx_dead) begin tx_busy = 1'b1; busy_cnt = 10; end
      start_pend = new_start;
      for (int i = 0; i < NR; i++) begin
        if (rd[i] < feed[i].size()) begin
          h = feed[i][rd[i]];
          if (!req_valid[i]) rise_cyc[i] = cyc;
          req_valid[i] = 1'b1; req_data[8*i +: 8] = h[7:0]; req_last[i] = h[8];
        end else begin
          req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
        end
      end
    end
  end

  task automatic mark_base();
    ev_base = ev_cyc.size();
    for (int i = 0; i < NR; i++) rdy_base[i] = rdy_cnt[i];
  endtask

  task automatic do_reset();
    tx_dead = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    mark_base();
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    feed[r].push_back({l, d});
  endtask

  function automatic int nev();
    return ev_cyc.size() - ev_base;
  endfunction

  function automatic bit idle_now();
    bit q_empty;
    q_empty = 1'b1;
    for (int i = 0; i < NR; i++) if (rd[i] != feed[i].size()) q_empty = 1'b0;
    return q_empty && grant == '0 && !tx_busy && !start_pend;
  endfunction

  task automatic wait_events(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (nev() < n && k < budget) begin @(posedge clk); #1; k++; end
    ok = (nev() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!idle_now() && k < budget) begin @(posedge clk); #1; k++; end
    ok = idle_now();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 2'b00 || req_ready !== 2'b00) begin failures++;
      $display("FAIL reset_grant_ready: got grant=%b ready=%b expected 00/00", grant, req_ready); end
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || timeout !== 1'b0) begin failures++;
      $display("FAIL reset_tx: got start=%b data=%h timeout=%b expected 0/00/0", tx_start, tx_data, timeout); end
    #1 rst = 1'b0;
    mark_base();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (grant !== 2'b00 || tx_start !== 1'b0) begin failures++;
      $display("FAIL reset_idle: got grant=%b start=%b expected 00/0", grant, tx_start); end
  endtask

  task automatic test_single();
    bit ok1, ok2;
    int s;
    do_reset();
    push(0, 8'h34, 1'b1);
    wait_events(1, 50, ok1);
    wait_idle(100, ok2);
    checks++; if (!(ok1 && ok2)) begin failures++;
      $display("FAIL single_wait: got ok=%0d/%0d expected 1/1", ok1, ok2); end
    checks++; if (nev() != 1) begin failures++;
      $display("FAIL single_count: got %0d starts expected 1", nev()); end
    if (nev() >= 1) begin
      s = ev_cyc[ev_base];
      checks++; if (ev_d[ev_base] !== 8'h34 || ev_g[ev_base] !== 2'b01) begin failures++;
        $display("FAIL single_byte: got data=%h grant=%b expected 34/01", ev_d[ev_base], ev_g[ev_base]); end
      checks++; if (ev_r[ev_base] !== 2'b01) begin failures++;
        $display("FAIL single_ready: got %b expected 01", ev_r[ev_base]); end
      checks++; if (s - rise_cyc[0] != 2) begin failures++;
        $display("FAIL single_latency: got %0d expected 2", s - rise_cyc[0]); end
      checks++; if (gh[s+11] !== 2'b01 || gh[s+12] !== 2'b00) begin failures++;
        $display("FAIL single_release: got %b,%b expected 01,00", gh[s+11], gh[s+12]); end
    end
    checks++; if (rdy_cnt[0] - rdy_base[0] != 1 || rdy_cnt[1] - rdy_base[1] != 0) begin failures++;
      $display("FAIL single_ready_count: got %0d/%0d expected 1/0",
               rdy_cnt[0] - rdy_base[0], rdy_cnt[1] - rdy_base[1]); end
    checks++; if (timeout !== 1'b0) begin failures++;
      $display("FAIL single_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d [4];
    logic [1:0] exp_g [4];
    bit ok;
    exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1); push(1, 8'h21, 1'b1);
    wait_idle(300, ok);
    checks++; if (!ok || nev() != 4) begin failures++;
      $display("FAIL contention_count: got ok=%0d starts=%0d expected 1/4", ok, nev()); end
    for (int k = 0; k < 4 && k < nev(); k++) begin
      checks++; if (ev_d[ev_base+k] !== exp_d[k] || ev_g[ev_base+k] !== exp_g[k]) begin failures++;
        $display("FAIL contention_order[%0d]: got %h/%b expected %h/%b",
                 k, ev_d[ev_base+k], ev_g[ev_base+k], exp_d[k], exp_g[k]); end
    end
  endtask

  task automatic test_packet_lock();
    logic [7:0] exp_d [4];
    logic [1:0] exp_g [4];
    bit ok1, ok2;
    exp_d = '{8'h41, 8'h42, 8'h43, 8'h30};
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
    wait_events(1, 50, ok1);
    push(0, 8'h30, 1'b1);
    wait_idle(300, ok2);
    checks++; if (!(ok1 && ok2) || nev() != 4) begin failures++;
      $display("FAIL lock_count: got ok=%0d/%0d starts=%0d expected 1/1/4", ok1, ok2, nev()); end
    for (int k = 0; k < 4 && k < nev(); k++) begin
      checks++; if (ev_d[ev_base+k] !== exp_d[k] || ev_g[ev_base+k] !== exp_g[k]) begin failures++;
        $display("FAIL lock_order[%0d]: got %h/%b expected %h/%b",
                 k, ev_d[ev_base+k], ev_g[ev_base+k], exp_d[k], exp_g[k]); end
    end
    if (nev() >= 3) begin
      checks++; if (ev_cyc[ev_base+1] - ev_cyc[ev_base] != 13 || ev_cyc[ev_base+2] - ev_cyc[ev_base+1] != 13)
      begin failures++;
        $display("FAIL lock_gap: got %0d,%0d expected 13,13",
                 ev_cyc[ev_base+1] - ev_cyc[ev_base], ev_cyc[ev_base+2] - ev_cyc[ev_base+1]); end
    end
  endtask

  task automatic test_lock_timeout();
    bit ok1, ok2;
    int s;
    do_reset();
    push(1, 8'h55, 1'b0);
    wait_events(1, 50, ok1);
    push(0, 8'hA0, 1'b1);
    wait_idle(300, ok2);
    checks++; if (!(ok1 && ok2) || nev() != 2) begin failures++;
      $display("FAIL locktmo_count: got ok=%0d/%0d starts=%0d expected 1/1/2", ok1, ok2, nev()); end
    if (nev() >= 2) begin
      s = ev_cyc[ev_base];
      checks++; if (ev_g[ev_base] !== 2'b10 || ev_d[ev_base] !== 8'h55) begin failures++;
        $display("FAIL locktmo_first: got %h/%b expected 55/10", ev_d[ev_base], ev_g[ev_base]); end
      checks++; if (gh[s+27] !== 2'b10 || gh[s+28] !== 2'b00) begin failures++;
        $display("FAIL locktmo_release: got %b,%b expected 10,00", gh[s+27], gh[s+28]); end
      checks++; if (ev_cyc[ev_base+1] - s != 30 || ev_g[ev_base+1] !== 2'b01 || ev_d[ev_base+1] !== 8'hA0)
      begin failures++;
        $display("FAIL locktmo_next: got dt=%0d %h/%b expected 30 a0/01",
                 ev_cyc[ev_base+1] - s, ev_d[ev_base+1], ev_g[ev_base+1]); end
    end
  endtask

  task automatic test_busy_timeout();
    bit ok1, ok2;
    int s;
    do_reset();
    tx_dead = 1'b1;
    push(0, 8'h77, 1'b1);
    wait_events(1, 50, ok1);
    repeat (12) @(posedge clk);
    #1;
    if (nev() >= 1) begin
      s = ev_cyc[ev_base];
      checks++; if (th[s+7] !== 1'b0 || th[s+8] !== 1'b1) begin failures++;
        $display("FAIL busytmo_flag: got %b,%b expected 0,1", th[s+7], th[s+8]); end
      checks++; if (gh[s+7] !== 2'b01 || gh[s+8] !== 2'b00) begin failures++;
        $display("FAIL busytmo_release: got %b,%b expected 01,00", gh[s+7], gh[s+8]); end
    end
    tx_dead = 1'b0;
    push(1, 8'h88, 1'b1);
    wait_idle(200, ok2);
    checks++; if (!(ok1 && ok2) || nev() != 2) begin failures++;
      $display("FAIL busytmo_count: got ok=%0d/%0d starts=%0d expected 1/1/2", ok1, ok2, nev()); end
    if (nev() >= 2) begin
      checks++; if (ev_g[ev_base+1] !== 2'b10 || ev_d[ev_base+1] !== 8'h88) begin failures++;
        $display("FAIL busytmo_next: got %h/%b expected 88/10", ev_d[ev_base+1], ev_g[ev_base+1]); end
    end
    checks++; if (timeout !== 1'b1) begin failures++;
      $display("FAIL busytmo_sticky: got %b expected 1", timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    do_reset();
    push(0, 8'h66, 1'b1);
    wait_events(1, 50, ok1);
    repeat (4) @(posedge clk);
    #2;
    checks++; if (grant !== 2'b01 || tx_data !== 8'h66) begin failures++;
      $display("FAIL midrst_pre: got grant=%b data=%h expected 01/66", grant, tx_data); end
    rst = 1'b1;
    #1;
    checks++; if (grant !== 2'b00 || tx_data !== 8'h00 || tx_start !== 1'b0 || req_ready !== 2'b00 || timeout !== 1'b0)
    begin failures++;
      $display("FAIL midrst_outputs: got grant=%b data=%h start=%b ready=%b tmo=%b expected all 0",
               grant, tx_data, tx_start, req_ready, timeout); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    mark_base();
    push(0, 8'h61, 1'b1);
    push(1, 8'h62, 1'b1);
    wait_idle(300, ok2);
    checks++; if (!(ok1 && ok2) || nev() != 2) begin failures++;
      $display("FAIL midrst_count: got ok=%0d/%0d starts=%0d expected 1/1/2", ok1, ok2, nev()); end
    if (nev() >= 2) begin
      checks++; if (ev_g[ev_base] !== 2'b01 || ev_d[ev_base] !== 8'h61 || ev_g[ev_base+1] !== 2'b10 || ev_d[ev_base+1] !== 8'h62)
      begin failures++;
        $display("FAIL midrst_order: got %h/%b,%h/%b expected 61/01,62/10",
                 ev_d[ev_base], ev_g[ev_base], ev_d[ev_base+1], ev_g[ev_base+1]); end
      checks++; if (ev_cyc[ev_base] - rise_cyc[0] != 2) begin failures++;
        $display("FAIL midrst_latency: got %0d expected 2", ev_cyc[ev_base] - rise_cyc[0]); end
    end
  endtask

  // Reference: whole packets are granted round-robin, starting after requester NR-1.
  task automatic test_random();
    logic [8:0] mq [NR][$];
    logic [1:0] eg [$];
    logic [7:0] ed [$];
    logic [8:0] h;
    logic [7:0] d;
    int         ptr, win, npk, len, c;
    bit         ok;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int r = 0; r < NR; r++) begin
        mq[r].delete();
        npk = $urandom_range(1, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            push(r, d, b == len - 1);
            mq[r].push_back({b == len - 1, d});
          end
        end
      end
      eg.delete(); ed.delete();
      ptr = NR - 1;
      while (mq[0].size() + mq[1].size() > 0) begin
        win = -1;
        for (int off = 1; off <= NR; off++) begin
          c = (ptr + off) % NR;
          if (win < 0 && mq[c].size() > 0) win = c;
        end
        do begin
          h = mq[win].pop_front();
          eg.push_back(2'(1 << win));
          ed.push_back(h[7:0]);
        end while (!h[8]);
        ptr = win;
      end
      wait_idle(3000, ok);
      checks++; if (!ok || nev() != eg.size()) begin failures++;
        $display("FAIL random_count[%0d]: got ok=%0d starts=%0d expected 1/%0d", round, ok, nev(), eg.size()); end
      for (int k = 0; k < eg.size() && k < nev(); k++) begin
        checks++; if (ev_g[ev_base+k] !== eg[k] || ev_d[ev_base+k] !== ed[k]) begin failures++;
          $display("FAIL random_byte[%0d.%0d]: got %h/%b expected %h/%b",
                   round, k, ev_d[ev_base+k], ev_g[ev_base+k], ed[k], eg[k]); end
      end
    end
  endtask

  initial begin : main
    checks = 0; failures = 0; tx_dead = 1'b0; ev_base = 0;
    for (int i = 0; i < NR; i++) rdy_base[i] = 0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_packet_lock();
    test_lock_timeout();
    test_busy_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
